// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control path: opcode values,
// datapath select encodings and the control FSM state type. Imported by the
// controller, the wait timer, the ALU decoder and the testbench.
package multicycle_ctrl_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_BNE   = 6'b000101;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;
   localparam logic [1:0] ALUOP_LOGIC = 2'b11;

   localparam logic [1:0] ALUSRCB_B      = 2'b00;
   localparam logic [1:0] ALUSRCB_FOUR   = 2'b01;
   localparam logic [1:0] ALUSRCB_IMM    = 2'b10;
   localparam logic [1:0] ALUSRCB_IMM_SH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_MEMADR,
      S_MEMRD,
      S_MEMWB,
      S_MEMWR,
      S_RTYPEEX,
      S_RTYPEWB,
      S_BEQEX,
      S_ADDIEX,
      S_ADDIWB,
      S_JEX,
      S_ILLEGAL,
      S_IMMEX,
      S_IMMWB,
      S_BNEEX
   } state_e;

endpackage

// File: rtl/mc_wait_timer.sv
// Memory wait timer for the multicycle controller.
// Counts consecutive not-ready cycles while the controller sits in a state
// that waits on memory, and flags the cycle in which the count reaches
// MEM_TIMEOUT with memory still not ready. MEM_TIMEOUT=0 disables the flag.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   active      - controller is in FETCH, MEMRD or MEMWR
//   mem_ready   - memory completes the access this cycle
//   timeout     - this cycle is the timeout cycle (combinational)
module mc_wait_timer
   import multicycle_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 15
) (
   input  logic clk,
   input  logic reset,
   input  logic active,
   input  logic mem_ready,
   output logic timeout
);

   localparam int TW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
   // Count value seen during the MEM_TIMEOUT-th consecutive not-ready cycle.
   localparam logic [TW-1:0] LAST = TW'(MEM_TIMEOUT - 1);

   logic [TW-1:0] cnt_q, cnt_d;

   assign timeout = (MEM_TIMEOUT != 0) && active && !mem_ready && (cnt_q == LAST);

   // Leaving a wait state only happens on mem_ready or timeout, so clearing on
   // those plus !active also covers every state change.
   always_comb begin
      cnt_d = cnt_q + TW'(1);
      if (!active || mem_ready || timeout) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for the multicycle MIPS datapath. Sequences each
// instruction over 3-5 states, waits on a memory ready handshake with a
// timeout, traps undefined opcodes and counts retired instructions.
// Optional feature macro: MC_EXT_OPS_EN (adds ANDI, ORI and BNE).
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   op                  - opcode from IR, stable from DECODE to next FETCH
//   mem_ready           - memory completes the access this cycle
//   pcwrite/branch/bne  - PC write: unconditional / if zero / if not zero
//   irwrite, iord       - IR load, memory address select (0=PC, 1=ALUOut)
//   memwrite, regwrite  - memory write strobe, register file write
//   regdst, memtoreg    - write register select, write data select
//   alusrca, alusrcb    - ALU operand selects
//   pcsrc, aluop        - next-PC select, ALU decoder control
//   illegal, mem_err    - one-cycle pulses: undefined opcode, memory timeout
//   instret             - retired-instruction count
//
// state      | meaning
// FETCH      | read instruction at PC, PC+4; waits for mem_ready
// DECODE     | register read, branch target into ALUOut
// MEMADR     | load/store address computation
// MEMRD      | load data read; waits for mem_ready
// MEMWB      | load data to register file
// MEMWR      | store data write; waits for mem_ready
// RTYPEEX    | R-type ALU operation
// RTYPEWB    | R-type result to rd
// BEQEX      | branch if equal
// ADDIEX     | add immediate
// ADDIWB     | immediate result to rt
// JEX        | jump
// ILLEGAL    | undefined opcode trap
// IMMEX      | ANDI/ORI ALU operation (MC_EXT_OPS_EN)
// IMMWB      | ANDI/ORI result to rt (MC_EXT_OPS_EN)
// BNEEX      | branch if not equal (MC_EXT_OPS_EN)
module multicycle_ctrl
   import multicycle_ctrl_pkg::*;
#(
   parameter int OP_W        = 6,
   parameter int ALUOP_W     = 2,
   parameter int CNT_W       = 32,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [OP_W-1:0]    op,
   input  logic               mem_ready,
   output logic               pcwrite,
   output logic               branch,
   output logic               bne,
   output logic               irwrite,
   output logic               iord,
   output logic               memwrite,
   output logic               regwrite,
   output logic               regdst,
   output logic               memtoreg,
   output logic               alusrca,
   output logic [1:0]         alusrcb,
   output logic [1:0]         pcsrc,
   output logic [ALUOP_W-1:0] aluop,
   output logic               illegal,
   output logic               mem_err,
   output logic [CNT_W-1:0]   instret
);

   localparam logic [OP_W-1:0] C_RTYPE = OP_W'(OP_RTYPE);
   localparam logic [OP_W-1:0] C_LW    = OP_W'(OP_LW);
   localparam logic [OP_W-1:0] C_SW    = OP_W'(OP_SW);
   localparam logic [OP_W-1:0] C_BEQ   = OP_W'(OP_BEQ);
   localparam logic [OP_W-1:0] C_ADDI  = OP_W'(OP_ADDI);
   localparam logic [OP_W-1:0] C_J     = OP_W'(OP_J);
`ifdef MC_EXT_OPS_EN
   localparam logic [OP_W-1:0] C_ANDI  = OP_W'(OP_ANDI);
   localparam logic [OP_W-1:0] C_ORI   = OP_W'(OP_ORI);
   localparam logic [OP_W-1:0] C_BNE   = OP_W'(OP_BNE);
`endif

   state_e           state_q, state_d;
   logic [CNT_W-1:0] instret_q, instret_d;
   logic             wait_active, timeout, retire;

   logic       pcwrite_c, branch_c, bne_c, irwrite_c, iord_c, memwrite_c;
   logic       regwrite_c, regdst_c, memtoreg_c, alusrca_c, illegal_c, mem_err_c;
   logic [1:0] alusrcb_c, pcsrc_c, aluop_c;

   assign wait_active = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);

   mc_wait_timer #(
      .MEM_TIMEOUT(MEM_TIMEOUT)
   ) u_wait_timer (
      .clk      (clk),
      .reset    (reset),
      .active   (wait_active),
      .mem_ready(mem_ready),
      .timeout  (timeout)
   );

   always_comb begin
      state_d    = state_q;
      retire     = 1'b0;
      pcwrite_c  = 1'b0;
      branch_c   = 1'b0;
      bne_c      = 1'b0;
      irwrite_c  = 1'b0;
      iord_c     = 1'b0;
      memwrite_c = 1'b0;
      regwrite_c = 1'b0;
      regdst_c   = 1'b0;
      memtoreg_c = 1'b0;
      alusrca_c  = 1'b0;
      illegal_c  = 1'b0;
      mem_err_c  = 1'b0;
      alusrcb_c  = ALUSRCB_B;
      pcsrc_c    = PCSRC_ALU;
      aluop_c    = ALUOP_ADD;
      case (state_q)
         S_FETCH: begin
            alusrcb_c = ALUSRCB_FOUR;
            if (mem_ready) begin
               irwrite_c = 1'b1;
               pcwrite_c = 1'b1;
               state_d   = S_DECODE;
            end
         end
         S_DECODE: begin
            alusrcb_c = ALUSRCB_IMM_SH;
            case (op)
               C_LW, C_SW: state_d = S_MEMADR;
               C_RTYPE:    state_d = S_RTYPEEX;
               C_BEQ:      state_d = S_BEQEX;
               C_ADDI:     state_d = S_ADDIEX;
               C_J:        state_d = S_JEX;
`ifdef MC_EXT_OPS_EN
               C_ANDI, C_ORI: state_d = S_IMMEX;
               C_BNE:         state_d = S_BNEEX;
`endif
               default:    state_d = S_ILLEGAL;
            endcase
         end
         S_MEMADR: begin
            alusrca_c = 1'b1;
            alusrcb_c = ALUSRCB_IMM;
            state_d   = (op == C_LW) ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            iord_c = 1'b1;
            if (mem_ready) state_d = S_MEMWB;
         end
         S_MEMWB: begin
            memtoreg_c = 1'b1;
            regwrite_c = 1'b1;
            retire     = 1'b1;
            state_d    = S_FETCH;
         end
         S_MEMWR: begin
            iord_c     = 1'b1;
            memwrite_c = 1'b1;
            if (mem_ready) begin
               retire  = 1'b1;
               state_d = S_FETCH;
            end
         end
         S_RTYPEEX: begin
            alusrca_c = 1'b1;
            aluop_c   = ALUOP_FUNCT;
            state_d   = S_RTYPEWB;
         end
         S_RTYPEWB: begin
            regdst_c   = 1'b1;
            regwrite_c = 1'b1;
            retire     = 1'b1;
            state_d    = S_FETCH;
         end
         S_BEQEX: begin
            alusrca_c = 1'b1;
            aluop_c   = ALUOP_SUB;
            branch_c  = 1'b1;
            pcsrc_c   = PCSRC_ALUOUT;
            retire    = 1'b1;
            state_d   = S_FETCH;
         end
         S_ADDIEX: begin
            alusrca_c = 1'b1;
            alusrcb_c = ALUSRCB_IMM;
            state_d   = S_ADDIWB;
         end
         S_ADDIWB: begin
            regwrite_c = 1'b1;
            retire     = 1'b1;
            state_d    = S_FETCH;
         end
         S_JEX: begin
            pcsrc_c   = PCSRC_JUMP;
            pcwrite_c = 1'b1;
            retire    = 1'b1;
            state_d   = S_FETCH;
         end
         S_ILLEGAL: begin
            illegal_c = 1'b1;
            state_d   = S_FETCH;
         end
`ifdef MC_EXT_OPS_EN
         S_IMMEX: begin
            alusrca_c = 1'b1;
            alusrcb_c = ALUSRCB_IMM;
            aluop_c   = ALUOP_LOGIC;
            state_d   = S_IMMWB;
         end
         S_IMMWB: begin
            regwrite_c = 1'b1;
            retire     = 1'b1;
            state_d    = S_FETCH;
         end
         S_BNEEX: begin
            alusrca_c = 1'b1;
            aluop_c   = ALUOP_SUB;
            bne_c     = 1'b1;
            pcsrc_c   = PCSRC_ALUOUT;
            retire    = 1'b1;
            state_d   = S_FETCH;
         end
`endif
         default: state_d = S_FETCH;
      endcase

      // Aborted access: keep the selects, drop every write enable, restart.
      if (timeout) begin
         pcwrite_c  = 1'b0;
         irwrite_c  = 1'b0;
         memwrite_c = 1'b0;
         regwrite_c = 1'b0;
         branch_c   = 1'b0;
         bne_c      = 1'b0;
         mem_err_c  = 1'b1;
         retire     = 1'b0;
         state_d    = S_FETCH;
      end
   end

   assign instret_d = retire ? instret_q + CNT_W'(1) : instret_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_FETCH;
         instret_q <= '0;
      end else begin
         state_q   <= state_d;
         instret_q <= instret_d;
      end
   end

   // Reset is synchronous but the outputs must already read zero while it is
   // held, so they are masked combinationally.
   assign pcwrite  = pcwrite_c  & ~reset;
   assign branch   = branch_c   & ~reset;
   assign bne      = bne_c      & ~reset;
   assign irwrite  = irwrite_c  & ~reset;
   assign iord     = iord_c     & ~reset;
   assign memwrite = memwrite_c & ~reset;
   assign regwrite = regwrite_c & ~reset;
   assign regdst   = regdst_c   & ~reset;
   assign memtoreg = memtoreg_c & ~reset;
   assign alusrca  = alusrca_c  & ~reset;
   assign illegal  = illegal_c  & ~reset;
   assign mem_err  = mem_err_c  & ~reset;
   assign alusrcb  = reset ? 2'b00 : alusrcb_c;
   assign pcsrc    = reset ? 2'b00 : pcsrc_c;
   assign aluop    = reset ? '0 : ALUOP_W'(aluop_c);
   assign instret  = reset ? '0 : instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;
   import multicycle_ctrl_pkg::*;

   localparam int OP_W    = 6;
   localparam int ALUOP_W = 3;
   localparam int CNT_W   = 4;
   localparam int MEM_TO  = 15;

   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic [OP_W-1:0]    op = '0;
   logic               mem_ready = 1'b1;
   logic               pcwrite, branch, bne, irwrite, iord, memwrite, regwrite;
   logic               regdst, memtoreg, alusrca, illegal, mem_err;
   logic [1:0]         alusrcb, pcsrc;
   logic [ALUOP_W-1:0] aluop;
   logic [CNT_W-1:0]   instret;

   multicycle_ctrl #(
      .OP_W(OP_W), .ALUOP_W(ALUOP_W), .CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TO)
   ) dut (
      .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
      .pcwrite(pcwrite), .branch(branch), .bne(bne), .irwrite(irwrite),
      .iord(iord), .memwrite(memwrite), .regwrite(regwrite), .regdst(regdst),
      .memtoreg(memtoreg), .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc),
      .aluop(aluop), .illegal(illegal), .mem_err(mem_err), .instret(instret)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       pcwrite, branch, bne, irwrite, iord, memwrite, regwrite;
      logic       regdst, memtoreg, alusrca;
      logic [1:0] alusrcb, pcsrc;
      logic [2:0] aluop;
      logic       illegal, mem_err;
   } outs_t;

   typedef struct {
      outs_t base;
      bit    waits;
      outs_t on_ready;
   } step_t;

   typedef struct {
      string       name;
      logic [5:0]  opc;
      logic [31:0] rdy;
      int          cycles, ret, ill, memw, regw, err;
   } vec_t;

   int total = 0;
   int bad = 0;
   step_t plan_q[$];
   vec_t  vecs[$];
   logic [CNT_W-1:0] exp_ret;

   function automatic outs_t dut_outs();
      outs_t o;
      o = '{pcwrite, branch, bne, irwrite, iord, memwrite, regwrite, regdst,
            memtoreg, alusrca, alusrcb, pcsrc, aluop, illegal, mem_err};
      return o;
   endfunction

   function automatic outs_t fetch_ready_outs();
      outs_t o = '0;
      o.pcwrite = 1'b1; o.irwrite = 1'b1; o.alusrcb = 2'b01;
      return o;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Instruction-level reference: each opcode expands to a list of micro-steps.
   function automatic void build_plan(input logic [5:0] opc, output bit retires);
      outs_t o, r, z;
      z = '0;
      plan_q.delete();
      o = '0; o.alusrcb = 2'b01;
      r = '0; r.irwrite = 1'b1; r.pcwrite = 1'b1;
      plan_q.push_back('{o, 1'b1, r});
      o = '0; o.alusrcb = 2'b11;
      plan_q.push_back('{o, 1'b0, z});
      retires = 1'b1;
      if (opc == OP_LW || opc == OP_SW) begin
         o = '0; o.alusrca = 1'b1; o.alusrcb = 2'b10;
         plan_q.push_back('{o, 1'b0, z});
         o = '0; o.iord = 1'b1;
         if (opc == OP_LW) begin
            plan_q.push_back('{o, 1'b1, z});
            o = '0; o.memtoreg = 1'b1; o.regwrite = 1'b1;
            plan_q.push_back('{o, 1'b0, z});
         end else begin
            o.memwrite = 1'b1;
            plan_q.push_back('{o, 1'b1, z});
         end
      end else if (opc == OP_RTYPE) begin
         o = '0; o.alusrca = 1'b1; o.aluop = 3'b010;
         plan_q.push_back('{o, 1'b0, z});
         o = '0; o.regdst = 1'b1; o.regwrite = 1'b1;
         plan_q.push_back('{o, 1'b0, z});
      end else if (opc == OP_BEQ) begin
         o = '0; o.alusrca = 1'b1; o.aluop = 3'b001; o.branch = 1'b1; o.pcsrc = 2'b01;
         plan_q.push_back('{o, 1'b0, z});
      end else if (opc == OP_ADDI) begin
         o = '0; o.alusrca = 1'b1; o.alusrcb = 2'b10;
         plan_q.push_back('{o, 1'b0, z});
         o = '0; o.regwrite = 1'b1;
         plan_q.push_back('{o, 1'b0, z});
      end else if (opc == OP_J) begin
         o = '0; o.pcsrc = 2'b10; o.pcwrite = 1'b1;
         plan_q.push_back('{o, 1'b0, z});
`ifdef MC_EXT_OPS_EN
      end else if (opc == OP_ANDI || opc == OP_ORI) begin
         o = '0; o.alusrca = 1'b1; o.alusrcb = 2'b10; o.aluop = 3'b011;
         plan_q.push_back('{o, 1'b0, z});
         o = '0; o.regwrite = 1'b1;
         plan_q.push_back('{o, 1'b0, z});
      end else if (opc == OP_BNE) begin
         o = '0; o.alusrca = 1'b1; o.aluop = 3'b001; o.bne = 1'b1; o.pcsrc = 2'b01;
         plan_q.push_back('{o, 1'b0, z});
`endif
      end else begin
         o = '0; o.illegal = 1'b1;
         plan_q.push_back('{o, 1'b0, z});
         retires = 1'b0;
      end
   endfunction

   // Runs one instruction from FETCH against the reference, random mem_ready.
   task automatic model_instr(input logic [5:0] opc, input int pct);
      bit    retires, rdy, abort;
      outs_t e;
      build_plan(opc, retires);
      foreach (plan_q[i]) begin
         for (int w = 0; w < MEM_TO + 1; w++) begin
            @(negedge clk);
            op = opc;
            rdy = ($urandom_range(99) < pct);
            mem_ready = rdy;
            #1;
            e = plan_q[i].base;
            if (plan_q[i].waits && rdy) e = outs_t'(e | plan_q[i].on_ready);
            abort = plan_q[i].waits && !rdy && (w + 1 == MEM_TO);
            if (abort) begin
               e.pcwrite = 1'b0; e.irwrite = 1'b0; e.memwrite = 1'b0;
               e.regwrite = 1'b0; e.branch = 1'b0; e.bne = 1'b0; e.mem_err = 1'b1;
            end
            chk("model_outs", 32'(dut_outs()), 32'(e));
            chk("model_instret", 32'(instret), 32'(exp_ret));
            if (abort) return;
            if (!plan_q[i].waits || rdy) break;
         end
      end
      if (retires) exp_ret = exp_ret + 1'b1;
   endtask

   // Direct run of a table entry: count cycles until the next FETCH and tally pulses.
   task automatic run_vec(input vec_t v);
      int cyc = 0, memw = 0, regw = 0, ill = 0, err = 0;
      bit done = 0;
      logic [CNT_W-1:0] ret0 = instret;
      for (int c = 0; c < 48 && !done; c++) begin
         @(negedge clk);
         op = OP_W'(v.opc);
         mem_ready = (c < 32) ? v.rdy[c] : 1'b1;
         #1;
         if (c == 0) chk({v.name, "_fetch"}, 32'(dut_outs()), 32'(fetch_ready_outs()));
         memw += int'(memwrite);
         regw += int'(regwrite);
         ill  += int'(illegal);
         err  += int'(mem_err);
         @(posedge clk); #1;
         if (alusrcb == 2'b01) begin
            done = 1;
            cyc = c + 1;
         end
      end
      chk({v.name, "_cycles"}, 32'(cyc), 32'(v.cycles));
      chk({v.name, "_retired"}, 32'(CNT_W'(instret - ret0)), 32'(v.ret));
      chk({v.name, "_illegal"}, 32'(ill), 32'(v.ill));
      chk({v.name, "_memwrite"}, 32'(memw), 32'(v.memw));
      chk({v.name, "_regwrite"}, 32'(regw), 32'(v.regw));
      chk({v.name, "_mem_err"}, 32'(err), 32'(v.err));
   endtask

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         reset = 1'b1;
         mem_ready = 1'b1;
         #1;
         chk("reset_outs", 32'(dut_outs()), 32'd0);
         chk("reset_instret", 32'(instret), 32'd0);
      end
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   initial begin
      logic [5:0] pool[9];
      vec_t vj;
      pool = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J, OP_ANDI, OP_ORI, OP_BNE};

      vecs.push_back('{"lw_wait2",  OP_LW,    32'hFFFF_FFE7, 7, 1, 0, 0, 1, 0});
      vecs.push_back('{"sw",        OP_SW,    32'hFFFF_FFFF, 4, 1, 0, 1, 0, 0});
      vecs.push_back('{"rtype",     OP_RTYPE, 32'hFFFF_FFFF, 4, 1, 0, 0, 1, 0});
      vecs.push_back('{"beq",       OP_BEQ,   32'hFFFF_FFFF, 3, 1, 0, 0, 0, 0});
      vecs.push_back('{"addi",      OP_ADDI,  32'hFFFF_FFFF, 4, 1, 0, 0, 1, 0});
      vecs.push_back('{"j",         OP_J,     32'hFFFF_FFFF, 3, 1, 0, 0, 0, 0});
      vecs.push_back('{"op_3f",     6'h3F,    32'hFFFF_FFFF, 3, 0, 1, 0, 0, 0});
      vecs.push_back('{"sw_timeout", OP_SW,   32'hFFFC_0007, 18, 0, 0, 14, 0, 1});
      vecs.push_back('{"sw_ready15", OP_SW,   32'hFFFE_0007, 18, 1, 0, 15, 0, 0});
`ifdef MC_EXT_OPS_EN
      vecs.push_back('{"bne",       OP_BNE,   32'hFFFF_FFFF, 3, 1, 0, 0, 0, 0});
      vecs.push_back('{"ori",       OP_ORI,   32'hFFFF_FFFF, 4, 1, 0, 0, 1, 0});
      vecs.push_back('{"andi",      OP_ANDI,  32'hFFFF_FFFF, 4, 1, 0, 0, 1, 0});
`else
      vecs.push_back('{"bne",       OP_BNE,   32'hFFFF_FFFF, 3, 0, 1, 0, 0, 0});
      vecs.push_back('{"ori",       OP_ORI,   32'hFFFF_FFFF, 3, 0, 1, 0, 0, 0});
`endif

      do_reset(3);
      foreach (vecs[i]) run_vec(vecs[i]);

      // Counter wrap: 17 retirements from reset in a 4-bit counter.
      do_reset(1);
      vj = vecs[5];
      for (int i = 0; i < 17; i++) run_vec(vj);
      chk("instret_wrap", 32'(instret), 32'd1);

      // Reset while a store is waiting: write strobe must vanish at once.
      for (int c = 0; c < 3; c++) begin
         @(negedge clk); op = OP_SW; mem_ready = 1'b1;
         @(posedge clk); #1;
      end
      @(negedge clk); mem_ready = 1'b0; #1;
      chk("sw_pending_memwrite", 32'(memwrite), 32'd1);
      @(negedge clk); reset = 1'b1; #1;
      chk("rst_mid_outs", 32'(dut_outs()), 32'd0);
      chk("rst_mid_instret", 32'(instret), 32'd0);
      @(posedge clk); #1; reset = 1'b0;
      @(negedge clk); mem_ready = 1'b1; #1;
      chk("rst_mid_fetch", 32'(dut_outs()), 32'(fetch_ready_outs()));
      chk("rst_mid_instret_after", 32'(instret), 32'd0);
      @(posedge clk); #1;

      // Randomised instruction stream against the reference.
      do_reset(1);
      exp_ret = '0;
      for (int n = 0; n < 300; n++) begin
         logic [5:0] opc;
         int pct;
         opc = ($urandom_range(3) == 0) ? 6'($urandom) : pool[$urandom_range(8)];
         case ($urandom_range(9))
            0:       pct = 4;
            1, 2, 3: pct = 75;
            default: pct = 100;
         endcase
         model_instr(opc, pct);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
